// File: rtl/ho_pkg.sv
// Shared definitions for the obfuscation wrapper's result path: word geometry
// and the serializer FSM state encoding.
package ho_pkg;

    localparam int HO_WORD_W = 128;
    localparam int HO_BYTES  = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_ACK   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_CSUM  = 3'd5
    } ser_state_e;

endpackage

// File: rtl/ho_word_fifo.sv
// DEPTH x W synchronous word FIFO. A push while full is refused even if a pop
// happens in the same cycle (no write-through); 'drop' flags the refused push.
module ho_word_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 128,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty,
    output logic          drop
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          wr_en;
    logic          rd_en;

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign dout  = mem[rd_ptr_q];

    always_comb begin
        wr_en    = push && !full;
        rd_en    = pop && !empty;
        drop     = push && full;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/uart_result_serializer.sv
// Buffers result words and sends each one MSB byte first over the
// TxD_start/TxD_busy handshake. Define SERIALIZER_CHKSUM_EN to append an XOR checksum byte.
module uart_result_serializer
    import ho_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int BYTES = HO_BYTES,
    localparam int W    = 8 * BYTES,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [W-1:0]  Din,
    input  logic          Din_vld,
    output logic          Din_rdy,
    input  logic          TxD_busy,
    output logic          TxD_start,
    output logic [7:0]    TxD_data,
    output logic          Busy,
    output logic          Overflow,
    output logic [LW-1:0] Level
);

    localparam int CW = (BYTES > 1) ? $clog2(BYTES) : 1;

    ser_state_e    state_q, state_d;
    logic [W-1:0]  sr_q, sr_d;
    logic [CW-1:0] byte_cnt_q, byte_cnt_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          overflow_q, overflow_d;
`ifdef SERIALIZER_CHKSUM_EN
    logic [7:0]    csum_q, csum_d;
    logic          csum_phase_q, csum_phase_d;
`endif

    logic          fifo_pop;
    logic [W-1:0]  fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_drop;
    logic          last_byte;

    ho_word_fifo #(
        .DEPTH (DEPTH),
        .W     (W)
    ) u_fifo (
        .clk   (CLK),
        .rst   (RST),
        .push  (Din_vld),
        .din   (Din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .level (Level),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    assign Din_rdy   = !fifo_full;
    assign TxD_start = tx_start_q;
    assign TxD_data  = tx_data_q;
    assign Overflow  = overflow_q;
    assign Busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign last_byte = (byte_cnt_q == CW'(BYTES - 1));

    always_comb begin
        state_d      = state_q;
        sr_d         = sr_q;
        byte_cnt_d   = byte_cnt_q;
        tx_start_d   = tx_start_q;
        tx_data_d    = tx_data_q;
        overflow_d   = overflow_q | fifo_drop;
        fifo_pop     = 1'b0;
`ifdef SERIALIZER_CHKSUM_EN
        csum_d       = csum_q;
        csum_phase_d = csum_phase_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                fifo_pop   = 1'b1;
                sr_d       = fifo_dout;
                byte_cnt_d = '0;
`ifdef SERIALIZER_CHKSUM_EN
                csum_d       = '0;
                csum_phase_d = 1'b0;
`endif
                state_d    = ST_START;
            end

            ST_START: begin
                if (!TxD_busy) begin
                    tx_data_d  = sr_q[W-1 -: 8];
                    tx_start_d = 1'b1;
                    state_d    = ST_ACK;
`ifdef SERIALIZER_CHKSUM_EN
                    if (!csum_phase_q) begin
                        csum_d = csum_q ^ sr_q[W-1 -: 8];
                    end
`endif
                end
            end

            // TxD_data is only ever loaded on the way into ACK, so it stays
            // stable for the whole request no matter how long the stall.
            ST_ACK: begin
                if (TxD_busy) begin
                    tx_start_d = 1'b0;
                    state_d    = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if (!TxD_busy) begin
                    sr_d       = sr_q << 8;
                    byte_cnt_d = byte_cnt_q + CW'(1);
`ifdef SERIALIZER_CHKSUM_EN
                    if (csum_phase_q) begin
                        state_d = ST_IDLE;
                    end else if (last_byte) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_START;
                    end
`else
                    state_d = last_byte ? ST_IDLE : ST_START;
`endif
                end
            end

`ifdef SERIALIZER_CHKSUM_EN
            // Park the checksum in the top byte and reuse the data handshake.
            ST_CSUM: begin
                sr_d         = {csum_q, {(W-8){1'b0}}};
                csum_phase_d = 1'b1;
                state_d      = ST_START;
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            sr_q         <= '0;
            byte_cnt_q   <= '0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= '0;
            overflow_q   <= 1'b0;
`ifdef SERIALIZER_CHKSUM_EN
            csum_q       <= '0;
            csum_phase_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_start_q   <= tx_start_d;
            tx_data_q    <= tx_data_d;
            overflow_q   <= overflow_d;
`ifdef SERIALIZER_CHKSUM_EN
            csum_q       <= csum_d;
            csum_phase_q <= csum_phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_result_serializer.sv
// Directed/randomized bench for uart_result_serializer against a byte-queue
// reference model and a behavioural transmitter.
module tb_uart_result_serializer;

    localparam int DEPTH = 4;
    localparam int BYTES = 16;
    localparam int W     = 8 * BYTES;
`ifdef SERIALIZER_CHKSUM_EN
    localparam int BPW   = BYTES + 1;
`else
    localparam int BPW   = BYTES;
`endif

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] Din = '0;
    logic         Din_vld = 1'b0;
    logic         Din_rdy;
    logic         TxD_busy;
    logic         TxD_start;
    logic [7:0]   TxD_data;
    logic         Busy;
    logic         Overflow;
    logic [2:0]   Level;

    int total = 0;
    int bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];

    int         busy_len     = 10;
    int         stall_left   = 0;
    int         tx_cnt       = 0;
    bit         force_busy   = 1'b0;
    int         start_pulses = 0;
    int         max_level    = 0;
    logic       prev_start   = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    uart_result_serializer #(
        .DEPTH (DEPTH),
        .BYTES (BYTES)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Din       (Din),
        .Din_vld   (Din_vld),
        .Din_rdy   (Din_rdy),
        .TxD_busy  (TxD_busy),
        .TxD_start (TxD_start),
        .TxD_data  (TxD_data),
        .Busy      (Busy),
        .Overflow  (Overflow),
        .Level     (Level)
    );

    initial forever #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Transmitter: accepts a byte when start is seen while idle, then stays
    // busy for busy_len cycles. stall_left delays acceptance of a request.
    initial begin
        TxD_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (prev_start && TxD_start) check("data_stable", TxD_data, prev_data);
            if (TxD_start && !prev_start) start_pulses++;
            if (int'(Level) > max_level) max_level = int'(Level);
            if (tx_cnt > 0) begin
                tx_cnt--;
            end else if (TxD_start && !force_busy) begin
                if (stall_left > 0) begin
                    stall_left--;
                end else begin
                    rx_q.push_back(TxD_data);
                    tx_cnt = busy_len;
                end
            end
            TxD_busy   = force_busy || (tx_cnt > 0);
            prev_start = TxD_start;
            prev_data  = TxD_data;
        end
    end

    // Expected byte stream for one word: MSB byte first, optional XOR byte.
    task automatic add_word(input logic [W-1:0] w);
        logic [7:0] cs;
        cs = 8'h00;
        for (int i = 0; i < BYTES; i++) begin
            exp_q.push_back(w[W-1-8*i -: 8]);
            cs = cs ^ w[W-1-8*i -: 8];
        end
`ifdef SERIALIZER_CHKSUM_EN
        exp_q.push_back(cs);
`endif
    endtask

    task automatic push_word(input logic [W-1:0] w);
        Din     = w;
        Din_vld = 1'b1;
        @(negedge CLK);
        Din_vld = 1'b0;
        Din     = '0;
    endtask

    function automatic logic [W-1:0] rand_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((Busy || TxD_busy) && n < 4000) begin
            @(negedge CLK);
            n++;
        end
        check(tag, n < 4000, 1'b1);
    endtask

    task automatic check_rx(input string tag);
        int n;
        check($sformatf("%s_len", tag), rx_q.size(), exp_q.size());
        n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), rx_q[i], exp_q[i]);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] ws[6];
        int n;

        // Reset state
        #2 RST = 1'b1;
        #1;
        check("rst_start", TxD_start, 1'b0);
        check("rst_data", TxD_data, 8'h00);
        check("rst_ovf", Overflow, 1'b0);
        check("rst_level", Level, 3'd0);
        check("rst_busy", Busy, 1'b0);
        check("rst_rdy", Din_rdy, 1'b1);
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);

        // Single known word, 10-cycle transmitter
        busy_len = 10;
        start_pulses = 0;
        w = 128'h00112233445566778899AABBCCDDEEFF;
        push_word(w);
        add_word(w);
        wait_idle("t1_idle");
        check("t1_pulses", start_pulses, BPW);
        check("t1_busy", Busy, 1'b0);
        check_rx("t1");

        // Three back-to-back pushes
        busy_len = 3;
        max_level = 0;
        for (int i = 0; i < 3; i++) ws[i] = rand_word();
        for (int i = 0; i < 3; i++) push_word(ws[i]);
        for (int i = 0; i < 3; i++) add_word(ws[i]);
        wait_idle("t2_idle");
        check("t2_maxlvl", max_level, 2);
        check_rx("t2");

        // Transmitter ignores the first request for 20 cycles
        busy_len = 2;
        stall_left = 20;
        w = rand_word();
        push_word(w);
        add_word(w);
        wait_idle("t3_idle");
        check("t3_stall_used", stall_left, 0);
        check_rx("t3");

        // Randomly spaced words, never more than the FIFO plus one in flight
        busy_len = int'($urandom_range(1, 6));
        for (int i = 0; i < DEPTH + 1; i++) begin
            w = rand_word();
            push_word(w);
            add_word(w);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        wait_idle("t4_idle");
        check("t4_ovf", Overflow, 1'b0);
        check_rx("t4");

        // Overflow: transmitter held busy, six pushes
        busy_len = 3;
        force_busy = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        for (int i = 0; i < 6; i++) ws[i] = rand_word();
        for (int i = 0; i < 6; i++) push_word(ws[i]);
        @(negedge CLK);
        check("t5_level", Level, 3'd4);
        check("t5_rdy", Din_rdy, 1'b0);
        check("t5_ovf", Overflow, 1'b1);
        check("t5_busy", Busy, 1'b1);
        for (int i = 0; i < 5; i++) add_word(ws[i]);
        force_busy = 1'b0;
        wait_idle("t5_idle");
        check("t5_ovf_sticky", Overflow, 1'b1);
        check_rx("t5");

        // Reset after the fifth byte of A with B queued
        busy_len = 4;
        ws[0] = rand_word();
        ws[1] = rand_word();
        push_word(ws[0]);
        push_word(ws[1]);
        n = 0;
        while (rx_q.size() < 5 && n < 2000) begin
            @(negedge CLK);
            n++;
        end
        check("t6_reached", rx_q.size(), 5);
        RST = 1'b1;
        #1;
        check("t6_start", TxD_start, 1'b0);
        check("t6_level", Level, 3'd0);
        check("t6_ovf", Overflow, 1'b0);
        check("t6_rdy", Din_rdy, 1'b1);
        check("t6_busy", Busy, 1'b0);
        rx_q.delete();
        exp_q.delete();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        w = rand_word();
        push_word(w);
        add_word(w);
        wait_idle("t6_idle");
        check_rx("t6");

        // Checksum-oriented words
        busy_len = 1;
        w = {BYTES{8'h01}};
        push_word(w);
        add_word(w);
        wait_idle("t7_idle");
        check_rx("t7");
        w = 128'hA5;
        push_word(w);
        add_word(w);
        wait_idle("t8_idle");
        check_rx("t8");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
